// File: rtl/keypad_decoder.sv
// keypad_decoder
//    Downstream stage of the keypad row scanner. Synchronises the raw column
//    lines, pairs each column sample with the row that produced it, and
//    debounces presses and releases over repeated scans of that row.
//
// Ports
//    clk_div      clock shared with the row scanner (one row per clock)
//    rst          synchronous, active-high reset
//    row[3:0]     one-hot row drive from the scanner
//    col[3:0]     raw asynchronous column sense, active-high
//    key_code     last accepted key, {row index, col index}
//    key_valid    one-cycle pulse when a new debounced press is accepted
//    key_held     high while the accepted key is considered pressed
//    key_release  one-cycle pulse when a debounced release completes
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no key; waiting for a single-column hit on any row
// ST_CANDIDATE | counting consecutive exact matches of the candidate key
// ST_PRESSED   | key accepted and held; other keys locked out
// ST_RELEASING | counting consecutive observations of the key released

module keypad_decoder #(
   parameter int DEBOUNCE_SCANS = 4,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk_div,
   input  logic       rst,
   input  logic [3:0] row,
   input  logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held,
   output logic       key_release
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CANDIDATE,
      ST_PRESSED,
      ST_RELEASING
   } state_t;

   // Column synchroniser and matching row delay line, stage 0 first.
   logic [SYNC_STAGES-1:0][3:0] col_sync_q, col_sync_d;
   logic [SYNC_STAGES-1:0][3:0] row_dly_q,  row_dly_d;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       cand_r_q, cand_r_d;
   logic [1:0]       cand_c_q, cand_c_d;
   logic [3:0]       key_code_q, key_code_d;
   logic             key_valid_q, key_valid_d;
   logic             key_held_q, key_held_d;
   logic             key_release_q, key_release_d;

   logic [3:0]       s_row, s_col;
   logic             s_row_ok, s_col_one_hot;
   logic [1:0]       s_r, s_c;
   logic             cand_hit, col_at_cand;
   logic [3:0]       cand_mask;
   logic [CNT_W-1:0] cnt_inc;

   always_comb begin
      col_sync_d    = col_sync_q;
      row_dly_d     = row_dly_q;
      col_sync_d[0] = col;
      row_dly_d[0]  = row;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         col_sync_d[i] = col_sync_q[i-1];
         row_dly_d[i]  = row_dly_q[i-1];
      end
   end

   assign s_row = row_dly_q[SYNC_STAGES-1];
   assign s_col = col_sync_q[SYNC_STAGES-1];

   // A non-one-hot delayed row (scanner glitch or reset fill) is a no-op.
   assign s_row_ok      = (s_row != 4'd0) && ((s_row & (s_row - 4'd1)) == 4'd0);
   assign s_col_one_hot = (s_col != 4'd0) && ((s_col & (s_col - 4'd1)) == 4'd0);

   always_comb begin
      s_r = 2'd0;
      case (s_row)
         4'b0010: s_r = 2'd1;
         4'b0100: s_r = 2'd2;
         4'b1000: s_r = 2'd3;
         default: s_r = 2'd0;
      endcase
   end

   always_comb begin
      s_c = 2'd0;
      case (s_col)
         4'b0010: s_c = 2'd1;
         4'b0100: s_c = 2'd2;
         4'b1000: s_c = 2'd3;
         default: s_c = 2'd0;
      endcase
   end

   assign cand_hit    = s_row_ok && (s_r == cand_r_q);
   assign cand_mask   = 4'b0001 << cand_c_q;
   assign col_at_cand = s_col[cand_c_q];
   assign cnt_inc     = cnt_q + CNT_ONE;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      cand_r_d      = cand_r_q;
      cand_c_d      = cand_c_q;
      key_code_d    = key_code_q;
      key_held_d    = key_held_q;
      key_valid_d   = 1'b0;
      key_release_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (s_row_ok && s_col_one_hot) begin
               state_d  = ST_CANDIDATE;
               cand_r_d = s_r;
               cand_c_d = s_c;
               cnt_d    = CNT_ONE;
            end
         end

         ST_CANDIDATE: begin
            if (cand_hit) begin
               // Any deviation from the exact single-column pattern drops
               // the candidate, including extra columns in the same row.
               if (s_col == cand_mask) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_d     = ST_PRESSED;
                     cnt_d       = '0;
                     key_code_d  = {cand_r_q, cand_c_q};
                     key_held_d  = 1'b1;
                     key_valid_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end
            end
         end

         ST_PRESSED: begin
            if (cand_hit && !col_at_cand) begin
               state_d = ST_RELEASING;
               cnt_d   = CNT_ONE;
            end
         end

         ST_RELEASING: begin
            if (cand_hit) begin
               if (!col_at_cand) begin
                  if (cnt_inc == CNT_DONE) begin
                     state_d       = ST_IDLE;
                     cnt_d         = '0;
                     key_held_d    = 1'b0;
                     key_release_d = 1'b1;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  // Release bounce: key is still down, no fresh key_valid.
                  state_d = ST_PRESSED;
                  cnt_d   = '0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk_div) begin
      if (rst) begin
         col_sync_q    <= '0;
         row_dly_q     <= '0;
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         cand_r_q      <= 2'd0;
         cand_c_q      <= 2'd0;
         key_code_q    <= 4'd0;
         key_valid_q   <= 1'b0;
         key_held_q    <= 1'b0;
         key_release_q <= 1'b0;
      end else begin
         col_sync_q    <= col_sync_d;
         row_dly_q     <= row_dly_d;
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cand_r_q      <= cand_r_d;
         cand_c_q      <= cand_c_d;
         key_code_q    <= key_code_d;
         key_valid_q   <= key_valid_d;
         key_held_q    <= key_held_d;
         key_release_q <= key_release_d;
      end
   end

   assign key_code    = key_code_q;
   assign key_valid   = key_valid_q;
   assign key_held    = key_held_q;
   assign key_release = key_release_q;

endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder
//    Bench for keypad_decoder with default parameters. A behavioural row
//    scanner rotates row every clock; col reflects the bench's "pressed key"
//    only while its row is driven. Expected key_valid / key_release events
//    are queued when the stimulus is applied and popped when the DUT pulses.

module tb_keypad_decoder;

   localparam int LAT_MAX = 19;

   logic       clk_div;
   logic       rst;
   logic [3:0] row;
   logic [3:0] col;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       key_release;

   keypad_decoder dut (
      .clk_div     (clk_div),
      .rst         (rst),
      .row         (row),
      .col         (col),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_held    (key_held),
      .key_release (key_release)
   );

   initial clk_div = 1'b0;
   always #5 clk_div = ~clk_div;

   typedef struct {
      logic [3:0] code;
      int         start;
   } exp_t;

   typedef struct {
      string      name;
      logic [3:0] row_oh;
      logic [3:0] col_pat;
      int         hold;
      bit         exp_valid;
      logic [3:0] exp_code;
      logic [3:0] code_after;
   } vec_t;

   exp_t exp_valid_q[$];
   int   exp_rel_q[$];

   int   total;
   int   bad;
   int   cyc;
   logic [3:0] key_row;
   logic [3:0] key_col;
   logic prev_valid, prev_release, prev_held;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_le(input string name, input int act, input int lim);
      total++;
      if (act > lim) begin
         bad++;
         $display("FAIL %s: got %0d, required <= %0d (cycle %0d)", name, act, lim, cyc);
      end
   endtask

   task automatic push_valid(input logic [3:0] code);
      exp_t e;
      e.code  = code;
      e.start = cyc;
      exp_valid_q.push_back(e);
   endtask

   task automatic push_rel();
      exp_rel_q.push_back(cyc);
   endtask

   // One clock: advance the scanner, drive col, then score the outputs.
   task automatic tick();
      exp_t e;
      int   s;
      @(posedge clk_div);
      #1;
      cyc++;
      row = {row[2:0], row[3]};
      col = (row == key_row) ? key_col : 4'b0000;

      if (key_valid) begin
         check("valid_expected", exp_valid_q.size() > 0, 1);
         if (exp_valid_q.size() > 0) begin
            e = exp_valid_q.pop_front();
            check("valid_code", key_code, e.code);
            check_le("valid_latency", cyc - e.start, LAT_MAX);
         end
         check("valid_not_consecutive", prev_valid, 0);
         check("valid_with_held", key_held, 1);
         check("valid_release_exclusive", key_release, 0);
      end
      if (key_release) begin
         check("release_expected", exp_rel_q.size() > 0, 1);
         if (exp_rel_q.size() > 0) begin
            s = exp_rel_q.pop_front();
            check_le("release_latency", cyc - s, LAT_MAX);
         end
         check("release_not_consecutive", prev_release, 0);
         check("release_held_fall", {prev_held, key_held}, 2'b10);
      end
      prev_valid   = key_valid;
      prev_release = key_release;
      prev_held    = key_held;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t vecs[5];
   bit   held_drop;

   initial begin
      vecs[0] = '{"glitch",   4'b0100, 4'b0010,  7, 1'b0, 4'h0, 4'h0};
      vecs[1] = '{"press_r2c1", 4'b0100, 4'b0010, 40, 1'b1, 4'h9, 4'h9};
      vecs[2] = '{"multi_col", 4'b0001, 4'b0011, 40, 1'b0, 4'h0, 4'h9};
      vecs[3] = '{"press_r0c3", 4'b0001, 4'b1000, 40, 1'b1, 4'h3, 4'h3};
      vecs[4] = '{"press_r3c0", 4'b1000, 4'b0001, 40, 1'b1, 4'hC, 4'hC};

      total        = 0;
      bad          = 0;
      cyc          = 0;
      key_row      = 4'b0000;
      key_col      = 4'b0000;
      prev_valid   = 1'b0;
      prev_release = 1'b0;
      prev_held    = 1'b0;
      row          = 4'b0001;
      col          = 4'b0000;
      rst          = 1'b1;

      run(2);
      check("reset_code",    key_code, 4'h0);
      check("reset_valid",   key_valid, 0);
      check("reset_held",    key_held, 0);
      check("reset_release", key_release, 0);
      rst = 1'b0;
      run(4);

      foreach (vecs[k]) begin
         key_row = vecs[k].row_oh;
         key_col = vecs[k].col_pat;
         if (vecs[k].exp_valid) push_valid(vecs[k].exp_code);
         run(vecs[k].hold);
         check({vecs[k].name, "_held"}, key_held, vecs[k].exp_valid);
         check({vecs[k].name, "_valid_arrived"}, exp_valid_q.size(), 0);
         key_col = 4'b0000;
         if (vecs[k].exp_valid) push_rel();
         run(24);
         check({vecs[k].name, "_held_after"}, key_held, 0);
         check({vecs[k].name, "_code_after"}, key_code, vecs[k].code_after);
         check({vecs[k].name, "_release_arrived"}, exp_rel_q.size(), 0);
      end

      // Release bounce: two released observations then eight pressed ones.
      key_row = 4'b0100;
      key_col = 4'b0010;
      push_valid(4'h9);
      run(40);
      check("bounce_press_held", key_held, 1);
      held_drop = 1'b0;
      key_col = 4'b0000;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!key_held) held_drop = 1'b1;
      end
      key_col = 4'b0010;
      for (int i = 0; i < 32; i++) begin
         tick();
         if (!key_held) held_drop = 1'b1;
      end
      check("bounce_held_throughout", held_drop, 0);
      check("bounce_code", key_code, 4'h9);
      key_col = 4'b0000;
      push_rel();
      run(24);
      check("bounce_final_release", exp_rel_q.size(), 0);

      // Reset while PRESSED, key kept down; it must re-qualify afterwards.
      key_col = 4'b0010;
      push_valid(4'h9);
      run(40);
      check("rstmid_held_before", key_held, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rstmid_held",    key_held, 0);
      check("rstmid_code",    key_code, 4'h0);
      check("rstmid_release", key_release, 0);
      check("rstmid_valid",   key_valid, 0);
      push_valid(4'h9);
      run(40);
      check("rstmid_requal_held", key_held, 1);
      check("rstmid_requal_arrived", exp_valid_q.size(), 0);
      key_col = 4'b0000;
      push_rel();
      run(24);
      check("rstmid_final_held", key_held, 0);

      check("end_valid_queue_empty",   exp_valid_q.size(), 0);
      check("end_release_queue_empty", exp_rel_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
